// File: rtl/reg_mem_pkg.sv
// Shared types and defaults for the two-read/one-write register-file memory
// and its clear sequencer.
package reg_mem_pkg;

  localparam int DEF_DATA_WIDTH     = 8;
  localparam int DEF_ADDR_BITS      = 5;
  localparam int DEF_CLEAR_ON_RESET = 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  function automatic int depth_of(input int addr_bits);
    return 1 << addr_bits;
  endfunction

endpackage

// File: rtl/reg_mem_clear_seq.sv
// Clear sequencer: walks the sweep counter over every address, reporting
// busy while it runs and a one-cycle clr_done pulse when it finishes.
module reg_mem_clear_seq
  import reg_mem_pkg::*;
#(
  parameter int ADDR_BITS      = DEF_ADDR_BITS,
  parameter int CLEAR_ON_RESET = DEF_CLEAR_ON_RESET
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  output state_e               state_o,
  output logic [ADDR_BITS-1:0] cnt_o,
  output logic                 busy_o,
  output logic                 clr_done_o
);

  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(depth_of(ADDR_BITS) - 1);
  localparam state_e RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
  localparam logic   RST_BUSY  = (CLEAR_ON_RESET != 0);

  state_e               state_q;
  logic [ADDR_BITS-1:0] cnt_q;
  logic                 busy_q;
  logic                 done_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      busy_q  <= RST_BUSY;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (clr_i) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          // clr is deliberately not looked at here: a running sweep never restarts.
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_ADDR) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign state_o    = state_q;
  assign cnt_o      = cnt_q;
  assign busy_o     = busy_q;
  assign clr_done_o = done_q;

endmodule

// File: rtl/reg_mem_2r1w.sv
// Register-file memory with one write port, two registered read ports with
// write-first bypass, and a hardware clear sweep.
module reg_mem_2r1w
  import reg_mem_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int ADDR_BITS      = DEF_ADDR_BITS,
  parameter int CLEAR_ON_RESET = DEF_CLEAR_ON_RESET
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wen,
  input  logic [ADDR_BITS-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_BITS-1:0]  raddr_a,
  input  logic [ADDR_BITS-1:0]  raddr_b,
  input  logic                  clr,
  output logic [DATA_WIDTH-1:0] data_out_a,
  output logic [DATA_WIDTH-1:0] data_out_b,
  output logic                  busy,
  output logic                  clr_done
);

  localparam int DEPTH = depth_of(ADDR_BITS);

  state_e                state;
  logic [ADDR_BITS-1:0]  sweep_addr;
  logic                  sweeping;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  mem_we_d;
  logic [ADDR_BITS-1:0]  mem_waddr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_d;
  logic [DATA_WIDTH-1:0] rd_a_d, rd_a_q;
  logic [DATA_WIDTH-1:0] rd_b_d, rd_b_q;

  reg_mem_clear_seq #(
    .ADDR_BITS      (ADDR_BITS),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_seq (
    .clk_i      (clk),
    .rst_i      (rst),
    .clr_i      (clr),
    .state_o    (state),
    .cnt_o      (sweep_addr),
    .busy_o     (busy),
    .clr_done_o (clr_done)
  );

  assign sweeping = (state == ST_CLEAR);

  // The sweep owns the write port while it runs; user writes are dropped.
  always_comb begin
    mem_we_d    = wen;
    mem_waddr_d = waddr;
    mem_wdata_d = data_in;
    if (sweeping) begin
      mem_we_d    = 1'b1;
      mem_waddr_d = sweep_addr;
      mem_wdata_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we_d) begin
      mem_q[mem_waddr_d] <= mem_wdata_d;
    end
  end

  // Write-first: a same-cycle write to the read address wins over the stored word.
  always_comb begin
    rd_a_d = '0;
    rd_b_d = '0;
    if (!sweeping) begin
      rd_a_d = (wen && (waddr == raddr_a)) ? data_in : mem_q[raddr_a];
      rd_b_d = (wen && (waddr == raddr_b)) ? data_in : mem_q[raddr_b];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_a_q <= '0;
      rd_b_q <= '0;
    end else begin
      rd_a_q <= rd_a_d;
      rd_b_q <= rd_b_d;
    end
  end

  assign data_out_a = rd_a_q;
  assign data_out_b = rd_b_q;

endmodule

// File: doc/reg_mem_2r1w.md
Name: reg_mem_2r1w

Overview:
Parametrised register-file memory with one write port and two independent registered read ports. It also has a hardware clear sequencer that zeroes every location, either after reset or on request. It is the next-generation general-purpose storage block: it feeds dual-operand datapaths (ALU A/B operands) where the single-port memory cannot serve two reads per cycle.

Parameters:
DATA_WIDTH, 8, width of each word in bits
ADDR_BITS, 5, address width; DEPTH = 2**ADDR_BITS words
CLEAR_ON_RESET, 1, 1 = run a clear sweep after reset; 0 = go straight to IDLE after reset

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  asynchronous, active-high reset
wen  input  1  write enable
waddr  input  ADDR_BITS  write address
data_in  input  DATA_WIDTH  write data
raddr_a  input  ADDR_BITS  read address, port A
raddr_b  input  ADDR_BITS  read address, port B
clr  input  1  single-cycle request to zero the whole memory
data_out_a  output  DATA_WIDTH  registered read data, port A
data_out_b  output  DATA_WIDTH  registered read data, port B
busy  output  1  high while the clear sweep runs
clr_done  output  1  one-cycle pulse when a sweep completes

Behaviour:
- Interface decision: one clock, clk; rst is asynchronous and active-high.
- Reset values:
  - data_out_a = 0, data_out_b = 0, clr_done = 0, sweep counter = 0.
  - CLEAR_ON_RESET=1: state = ST_CLEAR, busy = 1.
  - CLEAR_ON_RESET=0: state = ST_IDLE, busy = 0.
  - The storage array is not reset; it is cleared only by the sweep.
- States:
  - ST_IDLE: normal operation.
  - ST_CLEAR: writes 0 to mem[cnt] on each rising edge, then cnt++.
- Transitions:
  - ST_IDLE to ST_CLEAR when clr=1; cnt is loaded with 0 and busy goes to 1 on that edge.
  - ST_CLEAR to ST_IDLE on the edge that writes cnt = DEPTH-1. On that edge busy goes to 0 and clr_done goes to 1; clr_done returns to 0 on the following edge.
- Sweep timing: a full sweep takes exactly DEPTH edges. busy and clr_done are registered outputs.
- During ST_CLEAR:
  - wen is ignored; user writes are dropped, not queued.
  - clr is ignored; the sweep does not restart.
  - data_out_a and data_out_b are registered as 0.
- Write (ST_IDLE only): when wen=1, mem[waddr] <= data_in at the rising edge.
- Read latency is 1 cycle: data_out_x at edge k+1 equals the word at raddr_x sampled at edge k.
- Write-first bypass: if wen=1 and waddr == raddr_x in the same cycle, data_out_x gets data_in, never the stale word. Ports A and B apply the bypass independently. A == B addresses are legal and both ports return the same value.
- Address arithmetic: cnt is ADDR_BITS wide with no wrap beyond DEPTH-1; all addresses are full-range, with no out-of-range case.
- Reset asserted mid-sweep or mid-operation: outputs go to their reset values immediately (asynchronous). With CLEAR_ON_RESET=1 the sweep restarts from address 0.
- clr and wen in the same IDLE cycle: the write is performed on that edge, then the sweep begins and later zeroes that location.

Decomposition:
- Package reg_mem_pkg:
  - state typedef (ST_IDLE, ST_CLEAR);
  - DEPTH derivation helper;
  - default parameter constants.
- One natural sub-module, reg_mem_clear_seq: state register, sweep counter, busy and clr_done generation.
- Storage array, write mux (sweep vs user) and the read/bypass registers stay in the top module.

Test Plan:
All scenarios use default parameters (DEPTH = 32).
1. Assert rst for 3 cycles, then release -> busy=1 for exactly 32 edges; clr_done high for exactly one cycle after edge 32; data_out_a/b = 0 throughout; afterwards reads of addresses 0, 17 and 31 return 0.
2. Write i to address i for i = 0..31, then drive raddr_a=i and raddr_b=31-i -> one cycle later data_out_a=i and data_out_b=31-i for every i.
3. Same cycle: wen=1, waddr=5, data_in=8'hA5, raddr_a=5, raddr_b=6 (address 6 holds 6) -> next edge data_out_a=8'hA5, data_out_b=6.
4. Memory filled as in scenario 2; pulse clr; during sweep cycle 10 drive wen=1, waddr=3, data_in=8'hFF -> busy for 32 edges, one clr_done pulse; afterwards address 3 reads 0, as does every address.
5. Assert rst at sweep cycle 15 -> data_out_a/b, clr_done = 0 and busy = 1 immediately without a clock edge; after release the sweep runs a full 32 edges from address 0.
6. CLEAR_ON_RESET=0 -> busy=0 immediately after reset; write 8'h3C to address 9, read it next cycle -> data_out_a=8'h3C, with no sweep and no clr_done pulse.
